// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and defaults for the unified-memory port arbiter.
// Owner names carry an OWN_ prefix so they cannot collide with pipeline stage names.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RESP
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } owner_e;

  localparam int DEF_MEM_LAT       = 2;
  localparam int DEF_MAX_DM_STREAK = 3;

endpackage

// File: rtl/arb_prio.sv
// Grant selection between fetch and data requesters, with a DM streak counter
// that forces a fetch grant once DM has won MAX_DM_STREAK times in a row.
module arb_prio
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   can_issue,
  input  logic   if_req,
  input  logic   if_kill,
  input  logic   dm_req,
  output owner_e grant
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);

  logic [SW-1:0] streak;
  logic          if_ok;

  assign if_ok = if_req && !if_kill;

  always_comb begin
    grant = OWN_NONE;
    if (can_issue) begin
      if (if_ok && streak == SW'(MAX_DM_STREAK)) grant = OWN_IF;
      else if (dm_req)                          grant = OWN_DM;
      else if (if_ok)                           grant = OWN_IF;
    end
  end

  // The streak only measures DM wins while a fetch is actually waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak <= '0;
    end else if (!if_req || grant == OWN_IF) begin
      streak <= '0;
    end else if (grant == OWN_DM && streak != SW'(MAX_DM_STREAK)) begin
      streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and data-memory stages,
// sequencing fixed-latency reads and returning data with a one-cycle ready pulse.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT       = DEF_MEM_LAT,
  parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK,
  parameter int AW            = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_kill,
  output logic          if_ready,
  output logic [31:0]   if_rdata,
  input  logic          dm_req,
  input  logic          dm_wen,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          dm_ready,
  output logic [31:0]   dm_rdata,
  output logic          mem_en,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_e    state;
  owner_e        owner;
  owner_e        grant;
  logic [CW-1:0] lat_cnt;
  logic          kill_pend;
  logic          can_issue;
  logic          kill_hit;

  // Gating with reset keeps the memory strobe quiet while reset is held.
  assign can_issue = reset && (state == IDLE || state == RESP);
  assign kill_hit  = if_kill && state == RD_WAIT && owner == OWN_IF;

  arb_prio #(
    .MAX_DM_STREAK(MAX_DM_STREAK)
  ) u_arb_prio (
    .clk      (clk),
    .reset    (reset),
    .can_issue(can_issue),
    .if_req   (if_req),
    .if_kill  (if_kill),
    .dm_req   (dm_req),
    .grant    (grant)
  );

  always_comb begin
    mem_en    = (grant != OWN_NONE);
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (grant)
      OWN_IF: mem_addr = if_addr;
      OWN_DM: begin
        mem_addr  = dm_addr;
        mem_wen   = dm_wen;
        mem_wdata = dm_wdata;
      end
      default: ;
    endcase
  end

  assign busy     = (state != IDLE);
  assign if_ready = (state == RESP) && (owner == OWN_IF) && !kill_pend && !if_kill;
  assign dm_ready = (state == RESP) && (owner == OWN_DM);

  // A killed fetch still runs to completion on the memory side; only its result is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      lat_cnt   <= '0;
      kill_pend <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          kill_pend <= 1'b0;
          if (grant == OWN_NONE) begin
            state <= IDLE;
            owner <= OWN_NONE;
          end else begin
            owner <= grant;
            if (grant == OWN_DM && dm_wen) begin
              state <= RESP;
            end else begin
              state   <= RD_WAIT;
              lat_cnt <= CW'(MEM_LAT - 1);
            end
          end
        end
        RD_WAIT: begin
          if (kill_hit) kill_pend <= 1'b1;
          if (lat_cnt == '0) begin
            state <= RESP;
            if (owner == OWN_DM) dm_rdata <= mem_rdata;
            else if (!kill_pend && !kill_hit) if_rdata <= mem_rdata;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle model derived from the grant and
// latency rules is checked every cycle, alongside hand-computed literal expectations.
module tb_mem_port_arbiter;

  localparam int MEM_LAT       = 2;
  localparam int MAX_DM_STREAK = 3;
  localparam int AW            = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_kill = 1'b0;
  logic          if_ready;
  logic [31:0]   if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_wen = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [31:0]   dm_wdata = '0;
  logic          dm_ready;
  logic [31:0]   dm_rdata;
  logic          mem_en;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mem_port_arbiter #(
    .MEM_LAT      (MEM_LAT),
    .MAX_DM_STREAK(MAX_DM_STREAK),
    .AW           (AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_kill  (if_kill),
    .if_ready (if_ready),
    .if_rdata (if_rdata),
    .dm_req   (dm_req),
    .dm_wen   (dm_wen),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_ready (dm_ready),
    .dm_rdata (dm_rdata),
    .mem_en   (mem_en),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s @cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] fill(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Environment memory (driven by DUT outputs) and the model's own view of memory.
  logic [31:0] env_mem   [bit [31:0]];
  logic [31:0] model_mem [bit [31:0]];
  logic [31:0] rd_due    [int];

  bit          m_infl = 0;
  int          m_owner = 0;
  bit          m_read = 0;
  bit          m_killed = 0;
  int          m_resp_at = 0;
  int          m_streak = 0;
  logic [31:0] m_data = '0;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_dm_rdata = '0;

  task automatic model_step();
    bit          resp_now;
    bit          port_free;
    bit          if_ok;
    int          g;
    logic [31:0] e_addr;
    if (reset !== 1'b1) begin
      check_output("rst_mem_en",    32'(mem_en),    32'd0);
      check_output("rst_mem_wen",   32'(mem_wen),   32'd0);
      check_output("rst_mem_addr",  mem_addr,       32'd0);
      check_output("rst_mem_wdata", mem_wdata,      32'd0);
      check_output("rst_if_ready",  32'(if_ready),  32'd0);
      check_output("rst_dm_ready",  32'(dm_ready),  32'd0);
      check_output("rst_if_rdata",  if_rdata,       32'd0);
      check_output("rst_dm_rdata",  dm_rdata,       32'd0);
      check_output("rst_busy",      32'(busy),      32'd0);
      m_infl = 0; m_owner = 0; m_killed = 0; m_streak = 0;
      m_if_rdata = '0; m_dm_rdata = '0;
      return;
    end
    resp_now  = m_infl && (cyc == m_resp_at);
    port_free = !m_infl || resp_now;
    if_ok     = if_req && !if_kill;
    g = 0;
    if (port_free) begin
      if (if_ok && m_streak == MAX_DM_STREAK) g = 1;
      else if (dm_req)                        g = 2;
      else if (if_ok)                         g = 1;
    end
    e_addr = (g == 1) ? if_addr : dm_addr;
    check_output("busy",     32'(busy),     32'(m_infl));
    check_output("if_ready", 32'(if_ready), 32'(resp_now && m_owner == 1 && !m_killed && !if_kill));
    check_output("dm_ready", 32'(dm_ready), 32'(resp_now && m_owner == 2));
    check_output("if_rdata", if_rdata, m_if_rdata);
    check_output("dm_rdata", dm_rdata, m_dm_rdata);
    check_output("mem_en",   32'(mem_en),   32'(g != 0));
    check_output("mem_wen",  32'(mem_wen),  32'(g == 2 && dm_wen));
    if (g != 0) check_output("mem_addr", mem_addr, e_addr);
    if (g == 2 && dm_wen) check_output("mem_wdata", mem_wdata, dm_wdata);

    if (m_infl && m_owner == 1 && if_kill && !resp_now) m_killed = 1;
    if (m_infl && m_read && cyc == m_resp_at - 1) begin
      if (m_owner == 2) m_dm_rdata = m_data;
      else if (!m_killed) m_if_rdata = m_data;
    end
    if (resp_now) m_infl = 0;
    if (!if_req || g == 1) m_streak = 0;
    else if (g == 2 && m_streak < MAX_DM_STREAK) m_streak++;
    if (g != 0) begin
      m_infl    = 1;
      m_owner   = g;
      m_killed  = 0;
      m_read    = !(g == 2 && dm_wen);
      m_resp_at = cyc + (m_read ? MEM_LAT + 1 : 1);
      if (!m_read) model_mem[dm_addr] = dm_wdata;
      else m_data = model_mem.exists(e_addr) ? model_mem[e_addr] : fill(e_addr);
    end
  endtask

  initial begin
    env_mem[32'h100]    = 32'h0050_0093;
    env_mem[32'h2000]   = 32'hDEAD_BEEF;
    model_mem[32'h100]  = 32'h0050_0093;
    model_mem[32'h2000] = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      mem_rdata = rd_due.exists(cyc) ? rd_due[cyc] : 32'h5A5A_C3C3;
      #2;
      if (mem_en === 1'b1) begin
        if (mem_wen === 1'b1) env_mem[mem_addr] = mem_wdata;
        else rd_due[cyc + MEM_LAT] = env_mem.exists(mem_addr) ? env_mem[mem_addr] : fill(mem_addr);
      end
      model_step();
    end
  end

  task automatic wait_ready(input bit for_if, input int budget, output int rc);
    rc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (for_if ? (if_ready === 1'b1) : (dm_ready === 1'b1)) begin
        if (for_if) if_req = 1'b0;
        else dm_req = 1'b0;
        rc = cyc;
        break;
      end
    end
    if (rc < 0) begin
      total++;
      bad++;
      $display("[TB] FAIL ready_timeout: got no pulse, want one within %0d cycles", budget);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #3;
      if (busy === 1'b0) begin
        seen = 1;
        break;
      end
    end
    check_output("idle_reached", 32'(seen), 32'd1);
  endtask

  initial begin
    int          t;
    int          rc;
    int          n;
    logic [31:0] prev;
    logic [31:0] grants [5];
    logic [31:0] exp_g  [5];
    exp_g = '{32'h3000, 32'h3000, 32'h3000, 32'h200, 32'h3000};

    // Requests raised while reset is held must not reach the memory.
    if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h80; dm_addr = 32'h90;
    repeat (3) @(negedge clk);
    #3;
    check_output("reset_mem_en", 32'(mem_en), 32'd0);
    check_output("reset_busy",   32'(busy),   32'd0);
    @(negedge clk);
    reset = 1'b1; if_req = 1'b0; dm_req = 1'b0;
    #3;
    check_output("post_reset_busy",     32'(busy),     32'd0);
    check_output("post_reset_if_ready", 32'(if_ready), 32'd0);

    // Single fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    #3;
    check_output("fetch_issue_en",   32'(mem_en), 32'd1);
    check_output("fetch_issue_addr", mem_addr,    32'h100);
    t = cyc;
    wait_ready(1, 10, rc);
    check_output("fetch_latency", 32'(rc - t), 32'd3);
    check_output("fetch_rdata",   if_rdata,    32'h0050_0093);

    // Simultaneous fetch and load: DM first, fetch issued in the DM response cycle
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_wen = 1'b0; dm_addr = 32'h2000;
    #3;
    check_output("conflict_first_addr", mem_addr, 32'h2000);
    t = cyc;
    wait_ready(0, 10, rc);
    check_output("conflict_dm_latency", 32'(rc - t), 32'd3);
    #2;
    check_output("conflict_dm_rdata", dm_rdata,    32'hDEAD_BEEF);
    check_output("conflict_if_en",    32'(mem_en), 32'd1);
    check_output("conflict_if_addr",  mem_addr,    32'h104);
    wait_ready(1, 10, rc);
    check_output("conflict_if_latency", 32'(rc - t), 32'd6);
    check_output("conflict_if_rdata",   if_rdata,    32'hA5A5_0104);

    // Store then load back
    @(negedge clk);
    dm_req = 1'b1; dm_wen = 1'b1; dm_addr = 32'h2004; dm_wdata = 32'h1234_5678;
    #3;
    check_output("store_en",  32'(mem_en),  32'd1);
    check_output("store_wen", 32'(mem_wen), 32'd1);
    t = cyc;
    wait_ready(0, 5, rc);
    check_output("store_latency", 32'(rc - t), 32'd1);
    check_output("store_dm_rdata_kept", dm_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    dm_req = 1'b1; dm_wen = 1'b0; dm_addr = 32'h2004; dm_wdata = 32'h0;
    wait_ready(0, 10, rc);
    check_output("load_back_rdata", dm_rdata, 32'h1234_5678);

    // Streak guard with both requesters held
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_wen = 1'b0; dm_addr = 32'h3000;
    n = 0;
    for (int i = 0; i < 40 && n < 5; i++) begin
      #3;
      if (mem_en === 1'b1) begin
        grants[n] = mem_addr;
        n++;
      end
      if (n < 5) @(negedge clk);
    end
    check_output("streak_grant_count", 32'(n), 32'd5);
    for (int i = 0; i < n; i++) check_output($sformatf("streak_grant_%0d", i), grants[i], exp_g[i]);
    @(negedge clk);
    if_req = 1'b0; dm_req = 1'b0;
    wait_idle(20);

    // Fetch killed while in flight, no follow-up request
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h300;
    #3;
    prev = if_rdata;
    check_output("kill_issue_en", 32'(mem_en), 32'd1);
    @(negedge clk);
    if_kill = 1'b1; if_req = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      if (k == 2) if_kill = 1'b0;
      #3;
      check_output($sformatf("kill_no_ready_t%0d", k), 32'(if_ready), 32'd0);
    end
    check_output("kill_busy_t4",    32'(busy), 32'd0);
    check_output("kill_rdata_kept", if_rdata,  prev);

    // Fetch killed, new fetch issued in the killed response cycle
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h300;
    @(negedge clk);
    if_kill = 1'b1; if_req = 1'b0;
    @(negedge clk);
    if_kill = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h400;
    #1;
    check_output("rekill_no_ready", 32'(if_ready), 32'd0);
    #2;
    check_output("refetch_en",   32'(mem_en), 32'd1);
    check_output("refetch_addr", mem_addr,    32'h400);
    t = cyc;
    wait_ready(1, 10, rc);
    check_output("refetch_latency", 32'(rc - t), 32'd3);
    check_output("refetch_rdata",   if_rdata,    32'hA5A5_0400);

    // Kill landing exactly in the fetch response cycle
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h500;
    repeat (3) @(negedge clk);
    if_kill = 1'b1; if_req = 1'b0;
    #1;
    check_output("resp_kill_ready", 32'(if_ready), 32'd0);
    @(negedge clk);
    if_kill = 1'b0;

    // Kill in the same cycle as the request blocks the grant
    @(negedge clk);
    if_req = 1'b1; if_kill = 1'b1; if_addr = 32'h600;
    #3;
    check_output("same_cycle_kill_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    if_req = 1'b0; if_kill = 1'b0;

    // Reset during a read
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h700;
    #3;
    check_output("rst_mid_issue", 32'(mem_en), 32'd1);
    @(negedge clk);
    reset = 1'b0; if_req = 1'b0;
    #3;
    check_output("rst_mid_busy",  32'(busy),     32'd0);
    check_output("rst_mid_ready", 32'(if_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #3;
    check_output("rst_rel_if_ready", 32'(if_ready), 32'd0);
    check_output("rst_rel_dm_ready", 32'(dm_ready), 32'd0);
    @(negedge clk);
    #3;
    check_output("rst_idle_ready", 32'(if_ready), 32'd0);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    #3;
    t = cyc;
    wait_ready(1, 10, rc);
    check_output("rst_refetch_latency", 32'(rc - t), 32'd3);
    check_output("rst_refetch_rdata",   if_rdata,    32'h0050_0093);

    repeat (3) @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
